// File: rtl/pe_loop_addr_gen.sv
// Nested-loop address generator: walks up to NDEPTH loop levels odometer-style and
// emits base + sum(idx[k]*stride[k]) one word per cycle over a rdy/ack handshake.
module pe_loop_addr_gen #(
  parameter int NDEPTH  = 3,
  parameter int IDX_DW  = 4,
  parameter int ADDR_DW = 10
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            Cfg_rdy,
  output logic                            Cfg_ack,
  input  logic [NDEPTH-1:0][IDX_DW-1:0]   i_size,
  input  logic [NDEPTH-1:0][ADDR_DW-1:0]  i_stride,
  input  logic [ADDR_DW-1:0]              i_base,
  input  logic                            i_abort,
  output logic                            Addr_rdy,
  input  logic                            Addr_ack,
  output logic [ADDR_DW-1:0]              o_addr,
  output logic [NDEPTH-1:0][IDX_DW-1:0]   o_idx,
  output logic [NDEPTH-1:0]               o_loopEnd,
  output logic                            o_last,
  output logic                            o_done,
  output logic                            o_busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                           state;
  logic [NDEPTH-1:0][IDX_DW-1:0]    last_q;
  logic [NDEPTH-1:0][IDX_DW-1:0]    idx_q;
  logic [NDEPTH-1:0][ADDR_DW-1:0]   stride_q;
  logic [ADDR_DW-1:0]               base_q;
  logic [NDEPTH-1:0]                loop_end_q;

  // rb_q[k] is the address with every level below k at index 0, so rb_q[0] is the
  // current word and a carry into level k only needs one add per level.
  logic [NDEPTH-1:0][ADDR_DW-1:0]   rb_q;
  logic [NDEPTH-1:0][ADDR_DW-1:0]   rb_nxt;
  logic [NDEPTH-1:0][IDX_DW-1:0]    idx_nxt;
  logic [NDEPTH-1:0]                end_nxt;
  logic [NDEPTH-1:0][IDX_DW-1:0]    cfg_last;
  logic [NDEPTH-1:0]                cfg_end;

  always_comb begin : cfg_calc
    logic all_last;
    all_last = 1'b1;
    cfg_last = '0;
    cfg_end  = '0;
    for (int k = 0; k < NDEPTH; k++) begin
      cfg_last[k] = (i_size[k] == '0) ? '0 : i_size[k] - IDX_DW'(1);
      all_last    = all_last && (cfg_last[k] == '0);
      cfg_end[k]  = all_last;
    end
  end

  always_comb begin : step_calc
    logic                          carry;
    logic                          all_last;
    logic [ADDR_DW-1:0]            up;
    logic [NDEPTH-1:0]             bump;
    logic [NDEPTH-1:0]             wrap;
    logic [NDEPTH-1:0][IDX_DW-1:0] nidx;
    carry = 1'b1;
    bump  = '0;
    wrap  = '0;
    nidx  = idx_q;
    for (int k = 0; k < NDEPTH; k++) begin
      if (carry) begin
        if (idx_q[k] == last_q[k]) begin
          nidx[k] = '0;
          wrap[k] = 1'b1;
        end else begin
          nidx[k] = idx_q[k] + IDX_DW'(1);
          bump[k] = 1'b1;
          carry   = 1'b0;
        end
      end
    end
    up     = base_q;
    rb_nxt = rb_q;
    for (int k = NDEPTH - 1; k >= 0; k--) begin
      if (bump[k]) begin
        rb_nxt[k] = rb_q[k] + stride_q[k];
      end else if (wrap[k]) begin
        rb_nxt[k] = up;
      end
      up = rb_nxt[k];
    end
    all_last = 1'b1;
    end_nxt  = '0;
    for (int k = 0; k < NDEPTH; k++) begin
      all_last   = all_last && (nidx[k] == last_q[k]);
      end_nxt[k] = all_last;
    end
    idx_nxt = nidx;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= IDLE;
      last_q     <= '0;
      idx_q      <= '0;
      stride_q   <= '0;
      base_q     <= '0;
      rb_q       <= '0;
      loop_end_q <= '0;
    end else if (i_abort) begin
      state      <= IDLE;
      loop_end_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Cfg_rdy) begin
            last_q     <= cfg_last;
            stride_q   <= i_stride;
            base_q     <= i_base;
            idx_q      <= '0;
            rb_q       <= {NDEPTH{i_base}};
            loop_end_q <= cfg_end;
            state      <= RUN;
          end
        end
        RUN: begin
          if (Addr_ack) begin
            if (loop_end_q[NDEPTH-1]) begin
              loop_end_q <= '0;
              state      <= DONE;
            end else begin
              idx_q      <= idx_nxt;
              rb_q       <= rb_nxt;
              loop_end_q <= end_nxt;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign Cfg_ack   = (state == IDLE) && !i_abort;
  assign Addr_rdy  = (state == RUN);
  assign o_done    = (state == DONE);
  assign o_busy    = (state != IDLE);
  assign o_addr    = rb_q[0];
  assign o_idx     = idx_q;
  assign o_loopEnd = loop_end_q;
  assign o_last    = loop_end_q[NDEPTH-1];

endmodule
